// File: rtl/spike_synapse.sv
// spike_synapse: spike-edge weighted, saturating, exponentially decaying synaptic current (optional SYN_REFRACT_EN refractory window)
module spike_synapse #(
    parameter logic [7:0] WEIGHT         = 8'd40,
    parameter int         DECAY_SHIFT    = 2,
    parameter int         DECAY_PERIOD   = 4,
    parameter int         REFRACT_CYCLES = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] spike_in,
    input  logic       enable,
    input  logic       weight_load,
    input  logic [7:0] weight_in,
    output logic [7:0] stim_current,
    output logic       active
);
    typedef enum logic {IDLE, ACTIVE} state_t;
    localparam logic [7:0] RELOAD = 8'(DECAY_PERIOD - 1);
    state_t state, state_nx;
    logic [7:0] weight, cnt, cnt_nx, cur_nx, decayed, shr;
    logic [8:0] sum;
    logic spk, spk_d, spk_event, accept, tick;
    assign spk = |spike_in;
    assign spk_event = spk & ~spk_d & enable;
`ifdef SYN_REFRACT_EN
    logic [7:0] refr;
    assign accept = spk_event & (refr == 8'd0);
    always_ff @(posedge clk) begin
        if (!rst_n) refr <= 8'd0;
        else if (enable) refr <= accept ? 8'(REFRACT_CYCLES) : (refr != 8'd0) ? refr - 8'd1 : refr;
    end
`else
    logic unused_refract;
    assign unused_refract = REFRACT_CYCLES != 0;
    assign accept = spk_event;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            stim_current <= 8'd0;
            cnt          <= RELOAD;
            weight       <= WEIGHT;
            spk_d        <= 1'b0;
        end else begin
            spk_d <= spk;
            if (weight_load) weight <= weight_in;
            if (enable) begin
                state        <= state_nx;
                stim_current <= cur_nx;
                cnt          <= cnt_nx;
            end
        end
    end
    // Decay is applied before the weight so a coincident event lands on the decayed value
    always_comb begin
        tick     = (state == ACTIVE) && (cnt == 8'd0);
        shr      = stim_current >> DECAY_SHIFT;
        decayed  = !tick ? stim_current : (shr == 8'd0 && stim_current != 8'd0) ? stim_current - 8'd1 : stim_current - shr;
        sum      = {1'b0, decayed} + {1'b0, weight};
        cur_nx   = !accept ? decayed : sum[8] ? 8'hFF : sum[7:0];
        state_nx = (cur_nx != 8'd0) ? ACTIVE : IDLE;
        cnt_nx   = (state == IDLE || state_nx == IDLE || cnt == 8'd0) ? RELOAD : cnt - 8'd1;
    end
    always_comb begin
        active = (state == ACTIVE);
    end
endmodule
